// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg.sv
// Shared types and width helpers for the bufz shared-bus arbiter.
// Used by gf180mcu_fd_sc_mcu9t5v0__bufz_bus_arb and gf180mcu_fd_sc_mcu9t5v0__rr_pick.
package gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Dead counter holds DEAD-1 (DEAD is 1..7); hold counter holds up to MAX_HOLD-1 (<= 254).
  localparam int DEAD_W = 3;
  localparam int HOLD_W = 8;

  // Round-robin pointer / winner index width, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Returns the winner one-hot, its index and a valid flag.
module gf180mcu_fd_sc_mcu9t5v0__rr_pick
  import gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW-1:0] cand;

  // Scan N positions starting at ptr; the first requester seen wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        win[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_bus_arb.sv
// Round-robin arbiter and break-before-make enable sequencer for a bank of
// bufz tri-state drivers sharing one net. OE is the registered grant; a
// programmable dead time with all enables low separates any two grants.
// Optional feature macro: HOLD_TIMEOUT_EN (hold-time preemption with TOUT pulse).
//
// state | meaning
// IDLE  | no grant, arbitrate any pending request
// DRIVE | one buffer enabled, held until its REQ falls (or timeout)
// TURN  | all enables low for DEAD cycles, then arbitrate again
module gf180mcu_fd_sc_mcu9t5v0__bufz_bus_arb
  import gf180mcu_fd_sc_mcu9t5v0__bufz_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DEAD     = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic [N-1:0] REQ,
  output logic [N-1:0] GNT,
  output logic [N-1:0] OE,
  output logic         BUSY,
  output logic         TOUT,
  inout  wire          VDD,
  inout  wire          VSS
);

  localparam int                PW        = ptr_w(N);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD - 1);
  localparam logic [PW-1:0]     LAST_IDX  = PW'(N - 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     w_q, w_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [DEAD_W-1:0] dead_q, dead_d;

  logic [N-1:0]      pick_win;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic              release_w;
  logic              timeout_hit;

  // Power pins are pass-through only; fold them into a sink so they stay connected.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  gf180mcu_fd_sc_mcu9t5v0__rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .win   (pick_win),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign release_w = ~REQ[w_q];

`ifdef HOLD_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tout_q, tout_d;

  // Preempt only when someone else is waiting; an explicit release takes precedence.
  assign timeout_hit = (hold_q == HOLD_LAST) && (|(REQ & ~gnt_q));
  assign tout_d      = (state_q == DRIVE) && !release_w && timeout_hit;

  // Hold counter clears on any cycle not in DRIVE and saturates at its terminal count.
  always_comb begin
    hold_d = '0;
    if (state_q == DRIVE) begin
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      hold_q <= '0;
      tout_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tout_q <= tout_d;
    end
  end

  assign TOUT = tout_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^HOLD_W'(MAX_HOLD);
  assign timeout_hit     = 1'b0;
  assign TOUT            = 1'b0;
`endif

  // Next-state, grant, pointer and dead-counter logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    gnt_d   = gnt_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = DRIVE;
          w_d     = pick_idx;
          gnt_d   = pick_win;
        end
      end
      DRIVE: begin
        if (release_w || timeout_hit) begin
          state_d = TURN;
          gnt_d   = '0;
          dead_d  = DEAD_LOAD;
          ptr_d   = (w_q == LAST_IDX) ? '0 : w_q + 1'b1;
        end
      end
      TURN: begin
        gnt_d = '0;
        if (dead_q != '0) begin
          dead_d = dead_q - 1'b1;
        end else if (pick_valid) begin
          state_d = DRIVE;
          w_d     = pick_idx;
          gnt_d   = pick_win;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, pointer, winner, grant and dead-counter registers; reset drops OE at once.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      gnt_q   <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      gnt_q   <= gnt_d;
      dead_q  <= dead_d;
    end
  end

  assign GNT  = gnt_q;
  assign OE   = gnt_q;
  assign BUSY = (state_q != IDLE);

endmodule
